// File: rtl/vmx_job_sequencer.sv
// Host-side job controller for the VMX scratchpad/accelerator pair: loads operands,
// kicks the accelerator, waits for completion, then streams the result words out.
module vmx_job_sequencer #(
  parameter int unsigned LOAD_WORDS   = 8,
  parameter int unsigned RESULT_WORDS = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_start,
  input  logic         cfg_abort,
  input  logic [7:0]   cfg_rbase,
  input  logic [7:0]   cfg_wbase,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [63:0]  s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         m_last,
  output logic [7:0]   sp_addr,
  output logic         sp_we,
  output logic [63:0]  sp_wdata,
  input  logic [127:0] sp_rdata,
  output logic [31:0]  acc_ctrl,
  input  logic [31:0]  acc_flag,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FILL, ST_KICK, ST_WAIT, ST_RD, ST_CAP, ST_DONE
  } state_t;

  localparam logic [7:0]  LOAD_LAST = 8'(LOAD_WORDS - 1);
  localparam logic [7:0]  RES_LAST  = 8'(RESULT_WORDS - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  state_t       state_q, state_d;
  logic [7:0]   rbase_q, rbase_d;
  logic [7:0]   wbase_q, wbase_d;
  logic [7:0]   wcnt_q, wcnt_d;
  logic [7:0]   rcnt_q, rcnt_d;
  logic [15:0]  tcnt_q, tcnt_d;
  logic         seen_q, seen_d;
  logic         err_q, err_d;
  logic         cap_first_q, cap_first_d;
  logic [127:0] mdata_q, mdata_d;

  logic abort_hit;
  logic s_fire;
  logic m_fire;
  logic acc_idle;
  logic wait_complete;
  logic wait_expired;
  logic unused_flag_bits;

  // A job already in DONE is finishing anyway, so abort only acts in the working states.
  assign abort_hit     = cfg_abort && (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign s_fire        = (state_q == ST_FILL) && s_valid && !cfg_abort;
  assign m_fire        = (state_q == ST_CAP) && m_ready && !cfg_abort;
  assign acc_idle      = (acc_flag[2:0] == 3'd0);
  assign wait_complete = (state_q == ST_WAIT) && seen_q && acc_idle;
  assign wait_expired  = (state_q == ST_WAIT) && !wait_complete && (tcnt_q == TMO_LAST);
  assign unused_flag_bits = ^acc_flag[31:3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cfg_start) state_d = ST_FILL;
      ST_FILL: if (s_fire && (wcnt_q == LOAD_LAST)) state_d = ST_KICK;
      ST_KICK: state_d = ST_WAIT;
      ST_WAIT: begin
        if (wait_complete) begin
          state_d = ST_RD;
        end else if (wait_expired) begin
          state_d = ST_DONE;
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  if (m_fire) state_d = (rcnt_q == RES_LAST) ? ST_DONE : ST_RD;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_hit) state_d = ST_DONE;
  end

  always_comb begin
    rbase_d     = rbase_q;
    wbase_d     = wbase_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    tcnt_d      = tcnt_q;
    seen_d      = seen_q;
    err_d       = err_q;
    mdata_d     = mdata_q;
    cap_first_d = (state_q == ST_RD) && !abort_hit;
    if ((state_q == ST_IDLE) && cfg_start) begin
      rbase_d = cfg_rbase;
      wbase_d = cfg_wbase;
      wcnt_d  = 8'd0;
      rcnt_d  = 8'd0;
      tcnt_d  = 16'd0;
      seen_d  = 1'b0;
      err_d   = 1'b0;
    end
    if (s_fire) wcnt_d = wcnt_q + 8'd1;
    if (state_q == ST_WAIT) begin
      tcnt_d = tcnt_q + 16'd1;
      if (!acc_idle) seen_d = 1'b1;
    end
    // Read data is only valid on the first CAP cycle; hold it for stalled cycles.
    if ((state_q == ST_CAP) && cap_first_q) mdata_d = sp_rdata;
    if (m_fire) rcnt_d = rcnt_q + 8'd1;
    if (wait_expired || abort_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbase_q     <= 8'd0;
      wbase_q     <= 8'd0;
      wcnt_q      <= 8'd0;
      rcnt_q      <= 8'd0;
      tcnt_q      <= 16'd0;
      seen_q      <= 1'b0;
      err_q       <= 1'b0;
      cap_first_q <= 1'b0;
      mdata_q     <= 128'd0;
    end else begin
      rbase_q     <= rbase_d;
      wbase_q     <= wbase_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      tcnt_q      <= tcnt_d;
      seen_q      <= seen_d;
      err_q       <= err_d;
      cap_first_q <= cap_first_d;
      mdata_q     <= mdata_d;
    end
  end

  always_comb begin
    s_ready  = 1'b0;
    sp_we    = 1'b0;
    sp_addr  = 8'd0;
    sp_wdata = 64'd0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    m_data   = mdata_q;
    acc_ctrl = 32'd0;
    busy     = (state_q != ST_IDLE);
    done     = 1'b0;
    err      = err_q;
    case (state_q)
      ST_FILL: begin
        s_ready = !cfg_abort;
        sp_addr = rbase_q + wcnt_q;
        if (s_fire) begin
          sp_we    = 1'b1;
          sp_wdata = s_data;
        end
      end
      ST_KICK: acc_ctrl = 32'h2;
      ST_WAIT: if (wait_expired) acc_ctrl = 32'h1;
      ST_RD:   sp_addr = wbase_q + rcnt_q;
      ST_CAP: begin
        m_valid = !cfg_abort;
        m_last  = !cfg_abort && (rcnt_q == RES_LAST);
        if (cap_first_q) m_data = sp_rdata;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
    if (abort_hit) acc_ctrl = 32'h1;
  end

endmodule

// File: tb/tb_vmx_job_sequencer.sv
// Bench for vmx_job_sequencer: table of jobs with a write/result scoreboard,
// plus hand-written abort-in-FILL and reset-in-CAP sequences.
module tb_vmx_job_sequencer;
  localparam int LW = 8;
  localparam int RW = 4;
  localparam int NJ = 5;

  logic         clk;
  logic         rst_n;
  logic         cfg_start;
  logic         cfg_abort;
  logic [7:0]   cfg_rbase;
  logic [7:0]   cfg_wbase;
  logic         s_valid;
  logic         s_ready;
  logic [63:0]  s_data;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic         m_last;
  logic [7:0]   sp_addr;
  logic         sp_we;
  logic [63:0]  sp_wdata;
  logic [127:0] sp_rdata;
  logic [31:0]  acc_ctrl;
  logic [31:0]  acc_flag;
  logic         busy;
  logic         done;
  logic         err;

  vmx_job_sequencer #(.LOAD_WORDS(LW), .RESULT_WORDS(RW), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_rbase(cfg_rbase), .cfg_wbase(cfg_wbase),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .sp_addr(sp_addr), .sp_we(sp_we), .sp_wdata(sp_wdata), .sp_rdata(sp_rdata),
    .acc_ctrl(acc_ctrl), .acc_flag(acc_flag),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [7:0]  rbase;
    logic [7:0]  wbase;
    logic [63:0] dbase;
    bit          toggle;
    bit          stall;
    bit          stuck;
    bit          exp_err;
    int          exp_results;
    int          exp_abort_gap;
  } job_t;

  typedef struct { logic [7:0] addr; logic [63:0] data; } wr_t;
  typedef struct { logic [127:0] data; logic last; } res_t;

  wr_t  wq[$];
  res_t rq[$];
  job_t jobs[NJ];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_g = 0;
  int n_kick, n_apulse, n_hs, n_mv;
  int kick_cyc, apulse_cyc, last_hs_cyc, done_cyc;
  bit flag_stuck = 0;
  logic [2:0] fseq;
  logic         prev_stall;
  logic [127:0] prev_data;
  logic         prev_last;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_g++;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b required %0b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scratchpad port B model: registered read returning addr*0x11.
  always @(posedge clk) sp_rdata <= {116'd0, {4'd0, sp_addr} * 12'h011};

  // Accelerator model: after a start pulse the state walks 2,3,4 then returns to idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fseq <= 3'd0;
    else if (acc_ctrl == 32'h2 && !flag_stuck) fseq <= 3'd1;
    else if (acc_ctrl == 32'h1) fseq <= 3'd0;
    else if (fseq != 3'd0 && fseq < 3'd4) fseq <= fseq + 3'd1;
  end
  assign acc_flag = {29'd0, (fseq == 3'd1) ? 3'd2 : (fseq == 3'd2) ? 3'd3 :
                            (fseq == 3'd3) ? 3'd4 : 3'd0};

  always @(negedge clk) begin
    wr_t  w;
    res_t r;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (sp_we) begin
        if (wq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %02h data %0h, required no write", sp_addr, sp_wdata);
        end else begin
          w = wq.pop_front();
          $display("WR  addr=%02h data=%016h", sp_addr, sp_wdata);
          chki("wr_addr", int'(sp_addr), int'(w.addr));
          chkw("wr_data", {64'd0, sp_wdata}, {64'd0, w.data});
        end
      end
      if (acc_ctrl == 32'h2) begin
        n_kick++;
        kick_cyc = cyc_g;
      end else if (acc_ctrl == 32'h1) begin
        n_apulse++;
        apulse_cyc = cyc_g;
      end else if (acc_ctrl != 32'h0) begin
        chkw("acc_ctrl_legal", {96'd0, acc_ctrl}, 128'd0);
      end
      if (m_valid) n_mv++;
      if (prev_stall && !cfg_abort) begin
        chk1("stall_valid", m_valid, 1'b1);
        chkw("stall_data", m_data, prev_data);
        chk1("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        n_hs++;
        if (m_last) last_hs_cyc = cyc_g;
        if (rq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got data %0h, required no result", m_data);
        end else begin
          r = rq.pop_front();
          $display("RES data=%0h last=%0b", m_data, m_last);
          chkw("res_data", m_data, r.data);
          chk1("res_last", m_last, r.last);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) done_cyc = cyc_g;
    end
  end

  task automatic clear_stats();
    n_kick = 0; n_apulse = 0; n_hs = 0; n_mv = 0;
    kick_cyc = 0; apulse_cyc = 0; last_hs_cyc = 0; done_cyc = 0;
  endtask

  // Called and returns at posedge+1 with the DUT idle.
  task automatic run_job(input job_t j, input int k);
    int sent;
    int c;
    int stall_cnt;
    logic hs;
    logic [7:0] a;
    clear_stats();
    flag_stuck = j.stuck;
    for (int i = 0; i < LW; i++) wq.push_back('{addr: j.rbase + 8'(i), data: j.dbase + 64'(i + 1)});
    if (!j.stuck) begin
      for (int r = 0; r < RW; r++) begin
        a = j.wbase + 8'(r);
        rq.push_back('{data: {116'd0, {4'd0, a} * 12'h011}, last: (r == RW - 1)});
      end
    end
    cfg_rbase = j.rbase;
    cfg_wbase = j.wbase;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk1($sformatf("j%0d_s_ready_t1", k), s_ready, 1'b1);
    chk1($sformatf("j%0d_busy_t1", k), busy, 1'b1);
    chk1($sformatf("j%0d_err_cleared", k), err, 1'b0);
    sent = 0;
    c = 0;
    while (sent < LW && c < 200) begin
      s_valid = j.toggle ? (c % 2 == 0) : 1'b1;
      s_data  = j.dbase + 64'(sent + 1);
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      if (hs) sent++;
      c++;
    end
    s_valid = 1'b0;
    chki($sformatf("j%0d_fill_words", k), sent, LW);
    c = 0;
    stall_cnt = 0;
    while (!done && c < 600) begin
      if (m_valid) begin
        if (j.stall && stall_cnt < 3) begin
          m_ready = 1'b0;
          stall_cnt++;
        end else begin
          m_ready = 1'b1;
        end
      end else begin
        m_ready = 1'b0;
        stall_cnt = 0;
      end
      @(posedge clk); #1;
      c++;
    end
    m_ready = 1'b0;
    chk1($sformatf("j%0d_done_seen", k), done, 1'b1);
    chk1($sformatf("j%0d_err", k), err, j.exp_err);
    @(posedge clk); #1;
    chk1($sformatf("j%0d_idle_busy", k), busy, 1'b0);
    chk1($sformatf("j%0d_done_one_cycle", k), done, 1'b0);
    chki($sformatf("j%0d_results", k), n_hs, j.exp_results);
    chki($sformatf("j%0d_kicks", k), n_kick, 1);
    chki($sformatf("j%0d_abort_pulses", k), n_apulse, j.exp_err ? 1 : 0);
    chki($sformatf("j%0d_writes_left", k), wq.size(), 0);
    chki($sformatf("j%0d_results_left", k), rq.size(), 0);
    if (j.exp_err) begin
      chki($sformatf("j%0d_timeout_gap", k), apulse_cyc - kick_cyc, j.exp_abort_gap);
      chki($sformatf("j%0d_done_after_abort", k), done_cyc - apulse_cyc, 1);
      chki($sformatf("j%0d_no_m_valid", k), n_mv, 0);
    end else begin
      chki($sformatf("j%0d_done_after_last", k), done_cyc - last_hs_cyc, 1);
    end
    $display("JOB %0d rbase=%02h wbase=%02h results=%0d err=%0b", k, j.rbase, j.wbase, n_hs, err);
    wq.delete();
    rq.delete();
  endtask

  initial begin
    int c;
    jobs[0] = '{8'h10, 8'h40, 64'h000, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0};
    jobs[1] = '{8'h20, 8'h80, 64'h100, 1'b1, 1'b1, 1'b0, 1'b0, 4, 0};
    jobs[2] = '{8'hFC, 8'hFE, 64'h200, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0};
    jobs[3] = '{8'h30, 8'h50, 64'h300, 1'b0, 1'b0, 1'b1, 1'b1, 0, 255};
    jobs[4] = '{8'hFE, 8'hFF, 64'h400, 1'b1, 1'b1, 1'b0, 1'b0, 4, 0};

    rst_n = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_rbase = 8'd0; cfg_wbase = 8'd0;
    s_valid = 1'b0; s_data = 64'd0; m_ready = 1'b0;
    clear_stats();
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_s_ready", s_ready, 1'b0);
    chk1("rst_m_valid", m_valid, 1'b0);
    chk1("rst_m_last", m_last, 1'b0);
    chk1("rst_sp_we", sp_we, 1'b0);
    chki("rst_sp_addr", int'(sp_addr), 0);
    chkw("rst_acc_ctrl", {96'd0, acc_ctrl}, 128'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < NJ; k++) run_job(jobs[k], k);

    // Abort in FILL after three accepted words, with a fourth word offered.
    clear_stats();
    flag_stuck = 1'b0;
    for (int i = 0; i < 3; i++) wq.push_back('{addr: 8'h60 + 8'(i), data: 64'h500 + 64'(i)});
    cfg_rbase = 8'h60; cfg_wbase = 8'h00; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data = 64'h500 + 64'(i);
      @(posedge clk); #1;
    end
    s_data = 64'h503;
    cfg_abort = 1'b1;
    #1;
    chk1("abort_s_ready_drop", s_ready, 1'b0);
    chk1("abort_no_write", sp_we, 1'b0);
    chkw("abort_acc_ctrl", {96'd0, acc_ctrl}, 128'h1);
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    s_valid = 1'b0;
    chk1("abort_done", done, 1'b1);
    chk1("abort_err", err, 1'b1);
    @(posedge clk); #1;
    chk1("abort_idle", busy, 1'b0);
    chk1("abort_err_sticky", err, 1'b1);
    chki("abort_writes_left", wq.size(), 0);
    chki("abort_pulses", n_apulse, 1);
    chki("abort_no_kick", n_kick, 0);
    $display("JOB abort-in-FILL err=%0b", err);
    run_job(jobs[0], 10);

    // Reset while a result word is waiting in CAP.
    clear_stats();
    for (int i = 0; i < LW; i++) wq.push_back('{addr: 8'h70 + 8'(i), data: 64'h600 + 64'(i)});
    cfg_rbase = 8'h70; cfg_wbase = 8'h90; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int i = 0; i < LW; i++) begin
      s_valid = 1'b1;
      s_data = 64'h600 + 64'(i);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    c = 0;
    while (!m_valid && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    chk1("rstcap_reached_cap", m_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("rstcap_m_valid", m_valid, 1'b0);
    chk1("rstcap_busy", busy, 1'b0);
    chk1("rstcap_sp_we", sp_we, 1'b0);
    chkw("rstcap_acc_ctrl", {96'd0, acc_ctrl}, 128'd0);
    chkw("rstcap_m_data", m_data, 128'd0);
    chki("rstcap_writes_left", wq.size(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    $display("JOB reset-in-CAP busy=%0b", busy);
    run_job(jobs[2], 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
